// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// PC word-address width and the default reset PC.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int          PC_WORD_W        = 12;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Only bits [13:2] of a byte address are ever stored as the PC.
    function automatic logic [PC_WORD_W-1:0] pc_word(input logic [31:0] byte_addr);
        return byte_addr[PC_WORD_W+1:2];
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_register.sv
// 12-bit word-address PC register with synchronous reset value and load enable.
module pc_register
    import fetch_sequencer_pkg::*;
#(
    parameter logic [PC_WORD_W-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [PC_WORD_W-1:0] d,
    output logic [PC_WORD_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer: requests a word at pc,
// holds it until downstream accepts, then advances pc to new_pc.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      new_pc,
    input  logic             redirect,
    output logic [31:0]      pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [CNT_W-1:0] fetch_count
);

    state_t               state;
    logic [PC_WORD_W-1:0] pc_word_q;
    logic                 accept;
    logic                 pc_load;

    // A held instruction is accepted only in HOLD with a valid word present.
    assign accept  = (state == HOLD) && instr_valid && instr_ready;
    assign pc_load = redirect || accept;

    pc_register #(
        .RESET_VAL (pc_word(RESET_PC))
    ) u_pc_register (
        .clk  (clk),
        .rst  (rst),
        .load (pc_load),
        .d    (pc_word(new_pc)),
        .q    (pc_word_q)
    );

    assign pc        = {{(32-PC_WORD_W-2){1'b0}}, pc_word_q, 2'b00};
    assign imem_addr = pc;
    assign imem_req  = (state == FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            // Redirect drops any in-flight response but still credits an accept.
            state       <= FETCH;
            instr_valid <= 1'b0;
            if (accept) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        instr_valid <= 1'b0;
                        fetch_count <= fetch_count + 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (CNT_W=4 to exercise wrap).
module tb_fetch_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      new_pc;
    logic             redirect;
    logic [31:0]      pc;
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ready;
    logic [31:0]      imem_rdata;
    logic [31:0]      instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [CNT_W-1:0] fetch_count;

    logic             use_inc;
    logic [31:0]      fixed_pc;
    int               tests = 0;
    int               fails = 0;

    always #5 clk = ~clk;

    // new_pc either follows pc+4 (sequential flow) or a fixed target.
    always_comb new_pc = use_inc ? (pc + 32'd4) : fixed_pc;

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .new_pc      (new_pc),
        .redirect    (redirect),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_count (fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; use_inc = 1'b1; fixed_pc = '0;
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_cnt", {28'b0, fetch_count}, 32'h0);

        // Free-running flow: both handshakes tied high, pc advances by 4.
        rst = 1'b0; imem_ready = 1'b1; instr_ready = 1'b1; imem_rdata = 32'hA000_0000;
        chk("idle_req", {31'b0, imem_req}, 32'h0);
        step();
        chk("f0_req", {31'b0, imem_req}, 32'h1);
        chk("f0_addr", imem_addr, 32'h0);
        step();
        chk("h0_instr", instr, 32'hA000_0000);
        chk("h0_valid", {31'b0, instr_valid}, 32'h1);
        chk("h0_req", {31'b0, imem_req}, 32'h0);
        imem_rdata = 32'hA000_0004;
        step();
        chk("f1_addr", imem_addr, 32'h4);
        chk("f1_valid", {31'b0, instr_valid}, 32'h0);
        step();
        chk("h1_instr", instr, 32'hA000_0004);
        step();
        chk("f2_addr", imem_addr, 32'h8);
        step();
        step();
        chk("f3_addr", imem_addr, 32'hC);
        chk("f3_cnt", {28'b0, fetch_count}, 32'h3);

        // Memory stall at pc=0x10.
        step();
        imem_ready = 1'b0;
        step();
        chk("f4_addr", imem_addr, 32'h10);
        chk("f4_cnt", {28'b0, fetch_count}, 32'h4);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_addr", imem_addr, 32'h10);
            chk("stall_req", {31'b0, imem_req}, 32'h1);
        end
        imem_rdata = 32'h2108_0001; imem_ready = 1'b1; instr_ready = 1'b0;
        step();
        chk("latch_instr", instr, 32'h2108_0001);
        chk("latch_valid", {31'b0, instr_valid}, 32'h1);

        // Downstream stall in HOLD.
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_instr", instr, 32'h2108_0001);
            chk("hold_valid", {31'b0, instr_valid}, 32'h1);
            chk("hold_req", {31'b0, imem_req}, 32'h0);
            chk("hold_cnt", {28'b0, fetch_count}, 32'h4);
        end
        instr_ready = 1'b1;
        step();
        chk("rel_pc", pc, 32'h14);
        chk("rel_cnt", {28'b0, fetch_count}, 32'h5);

        // instr_ready with nothing held has no effect.
        step();
        chk("ign_req", {31'b0, imem_req}, 32'h1);
        chk("ign_cnt", {28'b0, fetch_count}, 32'h5);
        chk("ign_pc", pc, 32'h14);

        // Redirect beats imem_ready in FETCH.
        use_inc = 1'b0; fixed_pc = 32'h0000_0200; redirect = 1'b1;
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("rdf_pc", imem_addr, 32'h200);
        chk("rdf_valid", {31'b0, instr_valid}, 32'h0);
        chk("rdf_instr", instr, 32'h2108_0001);
        chk("rdf_req", {31'b0, imem_req}, 32'h1);
        redirect = 1'b0; imem_rdata = 32'h1111_2222; instr_ready = 1'b0;
        step();
        chk("rdf_fetch", instr, 32'h1111_2222);

        // Redirect with accept in HOLD still counts the instruction.
        fixed_pc = 32'h0000_0300; redirect = 1'b1; instr_ready = 1'b1;
        step();
        chk("rdh_pc", pc, 32'h300);
        chk("rdh_cnt", {28'b0, fetch_count}, 32'h6);
        chk("rdh_valid", {31'b0, instr_valid}, 32'h0);
        redirect = 1'b0;

        // Out-of-range new_pc is masked to a 12-bit word address.
        step();
        fixed_pc = 32'hFFFF_FFFF;
        step();
        chk("mask_pc", pc, 32'h0000_3FFC);
        chk("mask_cnt", {28'b0, fetch_count}, 32'h7);

        // Nine more accepts: 7 + 9 = 16 wraps a 4-bit counter to 0.
        use_inc = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            step();
        end
        chk("wrap_cnt", {28'b0, fetch_count}, 32'h0);

        // Reset in HOLD, with a simultaneous redirect, wins.
        instr_ready = 1'b0;
        step();
        chk("pre_rst_valid", {31'b0, instr_valid}, 32'h1);
        rst = 1'b1; redirect = 1'b1; use_inc = 1'b0; fixed_pc = 32'h0000_0400;
        step();
        chk("hrst_valid", {31'b0, instr_valid}, 32'h0);
        chk("hrst_pc", pc, 32'h0);
        chk("hrst_cnt", {28'b0, fetch_count}, 32'h0);
        chk("hrst_req", {31'b0, imem_req}, 32'h0);
        chk("hrst_instr", instr, 32'h0);

        // Redirect in IDLE.
        rst = 1'b0; fixed_pc = 32'h0000_0040; imem_ready = 1'b0;
        step();
        chk("idle_rd_pc", pc, 32'h40);
        chk("idle_rd_req", {31'b0, imem_req}, 32'h1);
        redirect = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset; bits [1:0] and [31:14] SHALL be zero.
REQ-002 Parameter CNT_W, default 16, is the width of the fetch counter.
REQ-003 clk  in  1  sole clock, rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 new_pc  in  32  next-PC from the PC-update datapath, computed from pc and the held instruction's decode.
REQ-006 redirect  in  1  late branch/jump resolution; forces refetch from new_pc.
REQ-007 pc  out  32  current PC, driven to the PC-update datapath.
REQ-008 imem_req  out  1  instruction-memory request.
REQ-009 imem_addr  out  32  request address, equal to pc.
REQ-010 imem_ready  in  1  memory response strobe, valid while imem_req=1.
REQ-011 imem_rdata  in  32  instruction word, valid with imem_ready.
REQ-012 instr  out  32  held instruction.
REQ-013 instr_valid  out  1  instr holds a valid instruction.
REQ-014 instr_ready  in  1  downstream accepts instr.
REQ-015 fetch_count  out  CNT_W  number of accepted instructions.

Function
REQ-016 The FSM SHALL have three states: IDLE, FETCH, and HOLD.
REQ-017 IDLE SHALL be entered on reset and SHALL go to FETCH on the next cycle, with imem_req=0.
REQ-018 In FETCH, imem_req SHALL be 1, and imem_addr SHALL stay stable until imem_ready=1.
REQ-019 In FETCH with imem_ready=1 and redirect=0, instr SHALL take imem_rdata, instr_valid SHALL be 1 from the next cycle, and the FSM SHALL go to HOLD.
REQ-020 In HOLD, imem_req SHALL be 0, and instr and instr_valid SHALL be held until instr_ready=1.
REQ-021 In HOLD with instr_ready=1 and redirect=0, pc SHALL load new_pc, instr_valid SHALL clear, fetch_count SHALL increment, and the FSM SHALL go to FETCH.
REQ-022 Minimum throughput SHALL be one instruction per 2 cycles when imem_ready and instr_ready are both tied high.
REQ-023 Whenever rst=0, redirect=1 in any state SHALL load pc from new_pc, clear instr_valid, and move the FSM to FETCH on the next cycle.
REQ-024 If redirect and imem_ready are both 1 in FETCH, redirect SHALL win, and imem_rdata SHALL be discarded.
REQ-025 If redirect and instr_ready are both 1 in HOLD, the instruction SHALL count as accepted (fetch_count increments) and pc SHALL still load new_pc.
REQ-026 redirect in IDLE SHALL load pc from new_pc, and the FSM SHALL go to FETCH.
REQ-027 On every pc load, bits [1:0] and [31:14] SHALL be forced to 0, so only new_pc[13:2] is stored (12-bit word address).
REQ-028 fetch_count SHALL wrap from all-ones to 0 without a flag.
REQ-029 instr_ready while instr_valid=0 SHALL be ignored.
REQ-030 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-031 When rst=1 at a rising edge, on the next cycle: pc=RESET_PC, state=IDLE, imem_req=0, instr=0, instr_valid=0, fetch_count=0.
REQ-032 Reset SHALL take priority over redirect and over all handshakes.
REQ-033 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the transaction; a late imem_ready SHALL be ignored because imem_req=0.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE, FETCH, HOLD), the PC word-address width (12), and the default RESET_PC.
REQ-035 One sub-module, pc_register, SHALL be instantiated: a 12-bit word-address register with synchronous reset value and load enable.
REQ-036 pc_register's output SHALL be zero-extended, with two zero LSBs appended, to form pc.
REQ-037 The FSM, instruction holding register, and counter SHALL reside in fetch_sequencer.

Verification
REQ-038 Reset release, RESET_PC=0, imem_ready=1, instr_ready=1 -> imem_req=0 on the first post-reset cycle; imem_addr=0, then 4, then 8 when new_pc=pc+4; fetch_count=3 after 6 cycles beyond IDLE.
REQ-039 imem_ready held 0 for 5 cycles at pc=0x10 -> imem_addr stays 0x10 with imem_req=1 throughout; instr=imem_rdata (0x2108_0001) latched on the ready cycle.
REQ-040 Stall: instr_ready=0 for 4 cycles in HOLD -> instr and instr_valid unchanged, imem_req=0, fetch_count unchanged.
REQ-041 redirect=1 with imem_ready=1 in FETCH, new_pc=0x0000_0200 -> data dropped, instr_valid=0, next imem_addr=0x200.
REQ-042 new_pc=0xFFFF_FFFF on accept -> pc=0x0000_3FFC; with CNT_W=4, 16 accepts -> fetch_count wraps to 0.
REQ-043 rst=1 asserted in HOLD with instr_valid=1 -> next cycle instr_valid=0, pc=RESET_PC, state IDLE, fetch_count=0.
